// File: rtl/mh_pkg.sv
// Shared types and helpers for the Marr-Hildreth convolution sequencer.
package mh_pkg;

  localparam int MH_WIDTH       = 8;
  localparam int MH_SIZE        = 10;
  localparam int MH_SIZE_KERNEL = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    WRITE = 2'd3
  } sched_state_t;

  // Row-major linear address of (row, col) in a square array of the given side.
  function automatic int unsigned mh_addr(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned side);
    return row * side + col;
  endfunction

  // Counter width able to hold 0..side-1 (never zero bits).
  function automatic int mh_cnt_w(input int side);
    return (side > 1) ? $clog2(side) : 1;
  endfunction

endpackage

// File: rtl/mh_grid_cnt.sv
// Two-dimensional wrap counter: col runs 0..SIDE-1, then row advances; both
// wrap to zero after (SIDE-1, SIDE-1). The next-state values are exported so
// the owner can register outputs that line up with the counter's new value.
module mh_grid_cnt
  import mh_pkg::*;
#(
  parameter int SIDE = 5,
  parameter int W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic [W-1:0] row_nx,
  output logic [W-1:0] col_nx,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(SIDE - 1);

  assign last = (row == MAX) && (col == MAX);

  // Next position: clear wins over increment; col wraps into a row step.
  always_comb begin
    row_nx = row;
    col_nx = col;
    if (clr) begin
      row_nx = '0;
      col_nx = '0;
    end else if (inc) begin
      if (col == MAX) begin
        col_nx = '0;
        row_nx = (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col_nx = col + 1'b1;
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nx;
      col <= col_nx;
    end
  end

endmodule

// File: rtl/mh_conv_sched.sv
// Sequencer for the Marr-Hildreth 5x5 convolution datapath. Walks every valid
// output pixel, issues one image/kernel BRAM read per tap, drives MAC control
// one cycle behind the reads (BRAM latency) and strobes the result write.
// Optional build macro MH_PERF_CNT_EN adds a perf_cycles run-length counter.
module mh_conv_sched
  import mh_pkg::*;
#(
  parameter int WIDTH       = MH_WIDTH,
  parameter int SIZE        = MH_SIZE,
  parameter int SIZE_KERNEL = MH_SIZE_KERNEL,
  parameter int OUT_SIZE    = SIZE - SIZE_KERNEL + 1,
  parameter int IMG_AW      = $clog2(SIZE * SIZE),
  parameter int KRN_AW      = $clog2(SIZE_KERNEL * SIZE_KERNEL),
  parameter int OUT_AW      = $clog2(OUT_SIZE * OUT_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              ready,
  output logic              done,
  output logic              img_rd_en,
  output logic [IMG_AW-1:0] img_addr,
  output logic              krn_rd_en,
  output logic [KRN_AW-1:0] krn_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr
`ifdef MH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int KW = mh_cnt_w(SIZE_KERNEL);
  localparam int PW = mh_cnt_w(OUT_SIZE);

  // No data flows through here; WIDTH only has to be sane for the datapath.
  if ((SIZE_KERNEL > SIZE) || (WIDTH < 1)) begin : g_param_check
    $error("mh_conv_sched: SIZE_KERNEL must not exceed SIZE and WIDTH must be positive");
  end

  sched_state_t  state, state_nx;
  logic [KW-1:0] kr, kc, kr_nx, kc_nx;
  logic [PW-1:0] orow, ocol, orow_nx, ocol_nx;
  logic          krn_last, pix_last;
  logic          start_acc, abort, tap0, krn_clr, pix_clr;

  assign start_acc = (state == IDLE) && start && !stop;
  assign abort     = (state != IDLE) && stop;
  assign tap0      = (kr == '0) && (kc == '0);
  assign krn_clr   = start_acc || abort || (state == WRITE);
  assign pix_clr   = start_acc || abort;

  mh_grid_cnt #(.SIDE(SIZE_KERNEL), .W(KW)) u_krn_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (krn_clr),
    .inc    (state == FETCH),
    .row    (kr),
    .col    (kc),
    .row_nx (kr_nx),
    .col_nx (kc_nx),
    .last   (krn_last)
  );

  mh_grid_cnt #(.SIDE(OUT_SIZE), .W(PW)) u_pix_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (pix_clr),
    .inc    (state == WRITE),
    .row    (orow),
    .col    (ocol),
    .row_nx (orow_nx),
    .col_nx (ocol_nx),
    .last   (pix_last)
  );

  // Next state: stop aborts any active state; start+stop together is refused.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc) state_nx = FETCH;
      FETCH:   if (stop) state_nx = IDLE;
               else if (krn_last) state_nx = FLUSH;
      FLUSH:   state_nx = stop ? IDLE : WRITE;
      WRITE:   state_nx = (stop || pix_last) ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Registered outputs. Read/write controls are decoded from the next state and
  // next counter values so they appear in the same cycle as the state they
  // describe. The MAC strobes form the second stage, one cycle behind the reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready     <= 1'b1;
      done      <= 1'b0;
      img_rd_en <= 1'b0;
      krn_rd_en <= 1'b0;
      img_addr  <= '0;
      krn_addr  <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      out_we    <= 1'b0;
      out_addr  <= '0;
    end else begin
      // Stage 0: tap issue towards the BRAMs.
      ready     <= (state_nx == IDLE);
      img_rd_en <= (state_nx == FETCH);
      krn_rd_en <= (state_nx == FETCH);
      if (state_nx == FETCH) begin
        img_addr <= IMG_AW'(mh_addr(32'(orow_nx) + 32'(kr_nx),
                                    32'(ocol_nx) + 32'(kc_nx), SIZE));
        krn_addr <= KRN_AW'(mh_addr(32'(kr_nx), 32'(kc_nx), SIZE_KERNEL));
      end
      // Stage 1: BRAM data valid, accumulate; abort flushes this stage.
      mac_en    <= img_rd_en && !abort;
      mac_first <= img_rd_en && tap0 && !abort;
      // Result write: pixel counters are stable through FLUSH.
      out_we    <= (state_nx == WRITE);
      if (state_nx == WRITE) begin
        out_addr <= OUT_AW'(mh_addr(32'(orow), 32'(ocol), OUT_SIZE));
      end
      done      <= (state == FLUSH) && !stop && pix_last;
    end
  end

`ifdef MH_PERF_CNT_EN
  logic [31:0] run_cnt;

  // Busy-cycle counter; the total is published only when a run completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt     <= '0;
      perf_cycles <= '0;
    end else begin
      if (start_acc)          run_cnt <= '0;
      else if (state != IDLE) run_cnt <= run_cnt + 32'd1;
      if ((state == WRITE) && pix_last) perf_cycles <= run_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mh_conv_sched.sv
// Self-checking bench for mh_conv_sched: cycle-exact reference timeline plus a
// golden 5x5 convolution scoreboard fed through the DUT's own read addresses.
module tb_mh_conv_sched;

  localparam int N   = 10;
  localparam int K   = 5;
  localparam int O   = N - K + 1;
  localparam int PIX = K * K + 2;
  localparam int RUN = O * O * PIX;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ready, done, img_rd_en, krn_rd_en, mac_en, mac_first, out_we;
  logic [6:0] img_addr;
  logic [4:0] krn_addr;
  logic [5:0] out_addr;
`ifdef MH_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cur_c  = 0;
  int img_mem [N*N];
  int krn_mem [K*K];
  int gold    [O*O];
  int res     [O*O];
  int ex_ia, ex_ka, ex_oa;
  int acc, pend, nwrites, ndone;

  mh_conv_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .ready     (ready),
    .done      (done),
    .img_rd_en (img_rd_en),
    .img_addr  (img_addr),
    .krn_rd_en (krn_rd_en),
    .krn_addr  (krn_addr),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .out_we    (out_we),
    .out_addr  (out_addr)
`ifdef MH_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cur_c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gold_calc();
    for (int r = 0; r < O; r++)
      for (int c = 0; c < O; c++) begin
        gold[r*O+c] = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            gold[r*O+c] += img_mem[(r+i)*N + c + j] * krn_mem[i*K+j];
      end
  endtask

  task automatic check_reset();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_img_rd_en", 32'(img_rd_en), 32'd0);
    check("rst_krn_rd_en", 32'(krn_rd_en), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_mac_first", 32'(mac_first), 32'd0);
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_img_addr", 32'(img_addr), 32'd0);
    check("rst_krn_addr", 32'(krn_addr), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
`ifdef MH_PERF_CNT_EN
    check("rst_perf", perf_cycles, 32'd0);
`endif
    ex_ia = 0; ex_ka = 0; ex_oa = 0;
  endtask

  // Expected outputs of cycle c of a run started in cycle 0 (aborted after
  // cycle stop_c when stop_c >= 0): pixel k occupies cycles 27k+1..27k+27 as
  // 25 tap reads, one flush and one write.
  task automatic check_cycle(input int c, input int stop_c);
    bit act, rd, me, mf, we, dn;
    int k, p;
    cur_c = c;
    rd = 0; me = 0; mf = 0; we = 0; dn = 0;
    act = (c >= 1) && (c <= RUN) && ((stop_c < 0) || (c <= stop_c));
    if (act) begin
      k  = (c - 1) / PIX;
      p  = (c - 1) % PIX;
      rd = (p < K*K);
      if (rd) begin
        ex_ia = ((k / O) + p / K) * N + (k % O) + p % K;
        ex_ka = p;
      end
      me = (p >= 1) && (p <= K*K);
      mf = (p == 1);
      we = (p == PIX - 1);
      if (we) ex_oa = k;
      dn = (c == RUN);
    end
    check("ready", 32'(ready), 32'(!act));
    check("img_rd_en", 32'(img_rd_en), 32'(rd));
    check("krn_rd_en", 32'(krn_rd_en), 32'(rd));
    check("img_addr", 32'(img_addr), ex_ia);
    check("krn_addr", 32'(krn_addr), ex_ka);
    check("mac_en", 32'(mac_en), 32'(me));
    check("mac_first", 32'(mac_first), 32'(mf));
    check("out_we", 32'(out_we), 32'(we));
    check("out_addr", 32'(out_addr), ex_oa);
    check("done", 32'(done), 32'(dn));
    // Scoreboard: data read last cycle arrives now.
    if (mac_en) acc = mac_first ? pend : acc + pend;
    if (out_we) begin
      res[out_addr] = acc;
      nwrites++;
    end
    if (done) ndone++;
    if (img_rd_en) pend = img_mem[img_addr] * krn_mem[krn_addr];
  endtask

  task automatic run(input int last_c, input int start_len, input int stop_c);
    nwrites = 0;
    ndone   = 0;
    foreach (res[i]) res[i] = -1;
    start = 1'b1;
    stop  = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      start = (c < start_len);
      stop  = (c == stop_c);
      check_cycle(c, stop_c);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic check_results(input int n);
    for (int i = 0; i < n; i++) check("result", res[i], gold[i]);
  endtask

  initial begin
    int s;
    foreach (img_mem[i]) img_mem[i] = i;
    foreach (krn_mem[i]) krn_mem[i] = int'($urandom_range(0, 255));
    gold_calc();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    cur_c = 0;
    check_reset();
    rst = 1'b1;
    tick();
    check_cycle(0, -1);

    // Full run on a ramp image, single-cycle start.
    run(RUN + 2, 1, -1);
    check("nwrites_a", nwrites, O*O);
    check("ndone_a", ndone, 1);
    check_results(O*O);
`ifdef MH_PERF_CNT_EN
    check("perf_a", perf_cycles, RUN);
`endif

    // Random image and kernel; start held high for the whole run.
    foreach (img_mem[i]) img_mem[i] = int'($urandom_range(0, 255));
    foreach (krn_mem[i]) krn_mem[i] = int'($urandom_range(0, 255));
    gold_calc();
    run(RUN + 3, RUN + 1, -1);
    check("nwrites_b", nwrites, O*O);
    check("ndone_b", ndone, 1);
    check_results(O*O);

    // Abort at cycle 300, then a fresh run restarting at pixel 0.
    run(310, 1, 300);
    check("nwrites_stop300", nwrites, 300 / PIX);
    check("ndone_stop300", ndone, 0);
    check_results(nwrites);
    foreach (krn_mem[i]) krn_mem[i] = int'($urandom_range(0, 255));
    gold_calc();
    run(RUN + 2, 1, -1);
    check("nwrites_d", nwrites, O*O);
    check("ndone_d", ndone, 1);
    check_results(O*O);
`ifdef MH_PERF_CNT_EN
    check("perf_d", perf_cycles, RUN);
`endif

    // Abort at a random cycle.
    s = int'($urandom_range(2, RUN - 1));
    run(s + 5, 1, s);
    check("nwrites_stop_rand", nwrites, s / PIX);
    check("ndone_stop_rand", ndone, 0);
    check_results(nwrites);
`ifdef MH_PERF_CNT_EN
    check("perf_after_abort", perf_cycles, RUN);
`endif

    // start and stop together in IDLE: the run must not begin.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_cycle(0, -1);
      tick();
    end

    // Asynchronous reset in the middle of a run, then a complete run.
    run(100, 1, -1);
    #3;
    rst = 1'b0;
    #1;
    cur_c = 100;
    check_reset();
    tick();
    rst = 1'b1;
    tick();
    check_cycle(0, -1);
    foreach (img_mem[i]) img_mem[i] = i;
    gold_calc();
    run(RUN + 2, 1, -1);
    check("nwrites_f", nwrites, O*O);
    check("ndone_f", ndone, 1);
    check_results(O*O);
`ifdef MH_PERF_CNT_EN
    check("perf_f", perf_cycles, RUN);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mh_conv_sched.md
Name: mh_conv_sched

Overview:
- Sequencer for the Marr-Hildreth 5x5 convolution datapath.
- Walks every valid output pixel of a SIZE x SIZE image.
- For each pixel it issues SIZE_KERNEL^2 image/kernel BRAM reads, drives MAC control aligned to the 1-cycle BRAM read latency, then strobes the result write.
- Sits between the AXI-Lite register bank (start/ready/stop) and the image/kernel/result memories behind the AXI-Full port.

Parameters:
- WIDTH, 8, pixel/coefficient width. Passed through for package consistency; no data passes through this block.
- SIZE, 10, image side length in pixels.
- SIZE_KERNEL, 5, kernel side length; must satisfy SIZE_KERNEL <= SIZE.
- OUT_SIZE, SIZE-SIZE_KERNEL+1 (=6), output side length (valid convolution, no padding).
- IMG_AW, $clog2(SIZE*SIZE), image address width.
- KRN_AW, $clog2(SIZE_KERNEL*SIZE_KERNEL), kernel address width.
- OUT_AW, $clog2(OUT_SIZE*OUT_SIZE), result address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- stop  in  1  abort the current run; highest priority after reset
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse on completion of a run
- img_rd_en  out  1  image BRAM read enable
- img_addr  out  IMG_AW  image address = row*SIZE+col
- krn_rd_en  out  1  kernel BRAM read enable (equal to img_rd_en)
- krn_addr  out  KRN_AW  kernel address = kr*SIZE_KERNEL+kc
- mac_en  out  1  accumulate this cycle's BRAM data
- mac_first  out  1  with mac_en: load the accumulator instead of adding
- out_we  out  1  result write strobe
- out_addr  out  OUT_AW  result address = orow*OUT_SIZE+ocol

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: FSM in IDLE; ready=1; all other outputs 0; all counters 0.
- States: IDLE, FETCH, FLUSH, WRITE.
- IDLE:
  - start=1 -> FETCH next cycle; orow=ocol=kr=kc=0; ready falls.
  - start=1 and stop=1 in the same cycle -> stay in IDLE.
- FETCH:
  - One tap per cycle: img_rd_en=krn_rd_en=1, img_addr=(orow+kr)*SIZE+(ocol+kc), krn_addr=kr*SIZE_KERNEL+kc.
  - kc increments each cycle; wraps at SIZE_KERNEL-1 and then increments kr.
  - On tap (SIZE_KERNEL-1, SIZE_KERNEL-1) -> FLUSH.
- MAC alignment: mac_en is img_rd_en delayed 1 cycle; mac_first is "tap 0 issued" delayed 1 cycle.
- FLUSH: no read; mac_en=1 for the last tap -> WRITE.
- WRITE:
  - out_we=1, out_addr=orow*OUT_SIZE+ocol.
  - ocol increments, wrapping at OUT_SIZE-1 with orow++; kr=kc=0.
  - Last pixel (OUT_SIZE-1, OUT_SIZE-1): done=1 this cycle, then -> IDLE.
  - Otherwise -> FETCH.
- Timing: one pixel takes SIZE_KERNEL^2+2 = 27 cycles. With the start-sample cycle numbered 0, pixel k writes in cycle 27(k+1). The last write and done occur in cycle 972; ready=1 from cycle 973.
- stop=1 in any non-IDLE state -> IDLE next cycle.
  - img_rd_en, mac_en, out_we and done are 0 from that next cycle on. The mac_en pipeline register is cleared.
  - No done pulse.
- start while busy is ignored.
- All outputs are registered; address outputs hold their last value when their enable is low.
- Arithmetic: all address products are unsigned and sized to the target width. Maximum img_addr = SIZE*SIZE-1, with no overflow.

Optional Feature:
- Macro: MH_PERF_CNT_EN.
- When defined:
  - Adds output perf_cycles (32 bits).
  - A counter clears on start acceptance and increments every non-IDLE cycle.
  - perf_cycles holds the count of the last completed run (972 for the defaults). It is not updated on stop. Reset value 0.
- When not defined: no port and no counter logic.

Decomposition:
- Package mh_pkg holds:
  - typedef enum logic [1:0] sched_state_t {IDLE, FETCH, FLUSH, WRITE};
  - default SIZE/SIZE_KERNEL/WIDTH localparams;
  - function mh_addr(row, col, side).
- Sub-module mh_grid_cnt: a 2-D wrap counter (row, col, inc, clr, last).
  - Instantiated twice: once for kernel taps (side SIZE_KERNEL), once for output pixels (side OUT_SIZE).

Test Plan:
- Reset mid-run: assert rst at cycle 100 -> outputs immediately at reset values, ready=1. After release, start gives a full 972-cycle run.
- Single run, defaults: start 1 cycle.
  - First reads at img_addr 0,1,2,3,4,10.
  - mac_first with the first mac_en only, at cycle 2.
  - out_we at cycles 27,54,...,972, out_addr 0..35.
  - Pixel 6 (orow=1, ocol=0) first img_addr = 10.
  - done only at cycle 972.
- Address bound: last FETCH tap of pixel 35 -> img_addr=99, krn_addr=24. Scoreboard with a golden 5x5 convolution on a ramp image confirms 36 results.
- stop at cycle 300 -> IDLE at cycle 301, no further out_we, no done. A new start then begins at pixel 0.
- start held high through the run is ignored. start+stop together in IDLE -> stays in IDLE.
- MH_PERF_CNT_EN defined -> perf_cycles=972 after the run; unchanged after an aborted run.
